// File: rtl/memory_issue_queue.sv
// memory_issue_queue: FIFO issue stage between execute and the data memory port.
// Load/store requests are queued with precomputed byte enables and lane-replicated
// store data. The head entry is presented on registered memory_* outputs and held
// until memory_ready_i.
//
// Optional feature macro: MEMORY_ISSUE_QUEUE_MISALIGN_CHECK_EN
//   defined   -> misaligned requests are dropped and misaligned_o pulses for one cycle
//   undefined -> misaligned_o is always 0 and every request is enqueued
//
// Ports:
//   clock_i          rising-edge clock
//   reset_i          asynchronous active-low reset
//   load_i/store_i   request strobes (store wins if both are set)
//   address_i        byte address
//   store_data_i     right-justified store value
//   log2_bytes_i     access size = 2^log2_bytes_i bytes
//   issue_ready_o    queue not full
//   misaligned_o     one-cycle pulse for a rejected misaligned request
//   queue_count_o    occupancy 0..QUEUE_DEPTH
//   memory_*_o       head entry (idle values when empty)
//   memory_ready_i   memory accepts the head entry on this edge
//   scan_i           simulation-only debug print enable
module memory_issue_queue #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int QUEUE_DEPTH     = 4,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000,
  localparam int unsigned NUM_BYTES      = DATA_WIDTH / 8,
  localparam int unsigned LOG2_NUM_BYTES = $clog2(NUM_BYTES),
  localparam int unsigned PTR_W          = $clog2(QUEUE_DEPTH),
  localparam int unsigned CNT_W          = PTR_W + 1
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      load_i,
  input  logic                      store_i,
  input  logic [ADDRESS_BITS-1:0]   address_i,
  input  logic [DATA_WIDTH-1:0]     store_data_i,
  input  logic [LOG2_NUM_BYTES-1:0] log2_bytes_i,
  output logic                      issue_ready_o,
  output logic                      misaligned_o,
  output logic [CNT_W-1:0]          queue_count_o,
  output logic                      memory_read_o,
  output logic                      memory_write_o,
  output logic [NUM_BYTES-1:0]      memory_byte_en_o,
  output logic [ADDRESS_BITS-1:0]   memory_address_o,
  output logic [DATA_WIDTH-1:0]     memory_data_o,
  input  logic                      memory_ready_i,
  input  logic                      scan_i
);

  // Queue storage
  logic                    st_mem_q   [QUEUE_DEPTH];
  logic [ADDRESS_BITS-1:0] addr_mem_q [QUEUE_DEPTH];
  logic [NUM_BYTES-1:0]    be_mem_q   [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem_q [QUEUE_DEPTH];

  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    issue_ready_q, issue_ready_d;
  logic                    misaligned_q, misaligned_d;
  logic                    read_q, read_d;
  logic                    write_q, write_d;
  logic [NUM_BYTES-1:0]    byte_en_q, byte_en_d;
  logic [ADDRESS_BITS-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic                    push_c;
  logic                    pop_c;
  logic [NUM_BYTES-1:0]    new_be_c;
  logic [DATA_WIDTH-1:0]   new_data_c;

  // Byte enables and lane-replicated data for the incoming request
  always_comb begin
    int size;
    int lo;
    int src;
    new_be_c   = '0;
    new_data_c = '0;
    size = 1 << int'(log2_bytes_i);
    lo   = int'(address_i[LOG2_NUM_BYTES-1:0]);
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      if (size >= int'(NUM_BYTES)) begin
        new_be_c[i] = 1'b1;
        src = i;
      end else begin
        // Shifted mask truncated at the top lane
        new_be_c[i] = (i >= lo) && (i < lo + size);
        src = i % size;
      end
      new_data_c[8*i +: 8] = store_data_i[8*src +: 8];
    end
  end

  // Push/pop decisions, pointers, count and next head view
  always_comb begin
    logic req;
    logic full;
    req           = load_i | store_i;
    full          = (count_q == CNT_W'(QUEUE_DEPTH));
    push_c        = 1'b0;
    misaligned_d  = 1'b0;
    pop_c         = (count_q != '0) && memory_ready_i;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    read_d        = 1'b0;
    write_d       = 1'b0;
    byte_en_d     = '1;
    address_d     = '0;
    data_d        = '0;

`ifdef MEMORY_ISSUE_QUEUE_MISALIGN_CHECK_EN
    begin
      logic [ADDRESS_BITS-1:0] align_mask;
      logic                    misalign;
      for (int i = 0; i < ADDRESS_BITS; i++) begin
        align_mask[i] = (i < int'(log2_bytes_i));
      end
      misalign     = |(address_i & align_mask);
      push_c       = req && !full && !misalign;
      misaligned_d = req && !full && misalign;
    end
`else
    push_c = req && !full;
`endif

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    issue_ready_d = (count_d != CNT_W'(QUEUE_DEPTH));

    // New head is the incoming entry when it lands at the post-edge read pointer
    if (count_d != '0) begin
      if (push_c && (rd_ptr_d == wr_ptr_q)) begin
        read_d    = !store_i;
        write_d   = store_i;
        byte_en_d = new_be_c;
        address_d = address_i;
        data_d    = new_data_c;
      end else begin
        read_d    = !st_mem_q[rd_ptr_d];
        write_d   = st_mem_q[rd_ptr_d];
        byte_en_d = be_mem_q[rd_ptr_d];
        address_d = addr_mem_q[rd_ptr_d];
        data_d    = data_mem_q[rd_ptr_d];
      end
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clock_i) begin
    if (push_c) begin
      st_mem_q[wr_ptr_q]   <= store_i;
      addr_mem_q[wr_ptr_q] <= address_i;
      be_mem_q[wr_ptr_q]   <= new_be_c;
      data_mem_q[wr_ptr_q] <= new_data_c;
    end
  end

  // Control state and registered head outputs
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      issue_ready_q <= 1'b1;
      misaligned_q  <= 1'b0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      byte_en_q     <= '1;
      address_q     <= '0;
      data_q        <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      issue_ready_q <= issue_ready_d;
      misaligned_q  <= misaligned_d;
      read_q        <= read_d;
      write_q       <= write_d;
      byte_en_q     <= byte_en_d;
      address_q     <= address_d;
      data_q        <= data_d;
    end
  end

  assign issue_ready_o    = issue_ready_q;
  assign misaligned_o     = misaligned_q;
  assign queue_count_o    = count_q;
  assign memory_read_o    = read_q;
  assign memory_write_o   = write_q;
  assign memory_byte_en_o = byte_en_q;
  assign memory_address_o = address_q;
  assign memory_data_o    = data_q;

`ifndef SYNTHESIS
  // Debug trace, simulation only
  int cycle_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) cycle_q <= 0;
    else          cycle_q <= cycle_q + 1;
  end

  always_ff @(posedge clock_i) begin
    if (scan_i && (cycle_q >= SCAN_CYCLES_MIN) && (cycle_q <= SCAN_CYCLES_MAX)) begin
      $display("core=%0d cycle=%0d count=%0d rd_ptr=%0d wr_ptr=%0d head r=%b w=%b addr=%h be=%b data=%h",
               CORE, cycle_q, count_q, rd_ptr_q, wr_ptr_q, read_q, write_q,
               address_q, byte_en_q, data_q);
    end
  end
`endif

endmodule

// File: tb/tb_memory_issue_queue.sv
// Testbench for memory_issue_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_memory_issue_queue;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int QD = 4;
  localparam int NB = 4;
  localparam int L2 = 2;

  logic          clock;
  logic          reset;
  logic          load;
  logic          store;
  logic [AW-1:0] address;
  logic [DW-1:0] store_data;
  logic [L2-1:0] log2_bytes;
  logic          issue_ready;
  logic          misaligned;
  logic [2:0]    queue_count;
  logic          memory_read;
  logic          memory_write;
  logic [NB-1:0] memory_byte_en;
  logic [AW-1:0] memory_address;
  logic [DW-1:0] memory_data;
  logic          memory_ready;
  logic          scan;

  memory_issue_queue #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .QUEUE_DEPTH(QD),
    .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
  ) dut (
    .clock_i(clock), .reset_i(reset), .load_i(load), .store_i(store),
    .address_i(address), .store_data_i(store_data), .log2_bytes_i(log2_bytes),
    .issue_ready_o(issue_ready), .misaligned_o(misaligned), .queue_count_o(queue_count),
    .memory_read_o(memory_read), .memory_write_o(memory_write),
    .memory_byte_en_o(memory_byte_en), .memory_address_o(memory_address),
    .memory_data_o(memory_data), .memory_ready_i(memory_ready), .scan_i(scan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit            st;
    logic [AW-1:0] a;
    logic [NB-1:0] be;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  bit   exp_mis;
  int   vectors;
  int   miscompares;

  // Byte mask from size and offset with plain arithmetic
  function automatic logic [NB-1:0] ref_be(logic [AW-1:0] a, int lb);
    int     size;
    int     lo;
    longint m;
    size = 1 << lb;
    lo   = int'(a % NB);
    if (lb >= L2) return '1;
    m = ((longint'(1) << size) - 1) << lo;
    return NB'(m);
  endfunction

  // Low 2^lb bytes repeated across the word
  function automatic logic [DW-1:0] ref_data(logic [DW-1:0] sd, int lb);
    int            size;
    longint        pat;
    logic [DW-1:0] r;
    size = 1 << lb;
    if (size > NB) size = NB;
    pat = longint'(sd) & ((longint'(1) << (8 * size)) - 1);
    r = '0;
    for (int k = 0; k < NB / size; k++) r = r | DW'(pat << (8 * size * k));
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    ent_t h;
    bit   e;
    e = (mq.size() == 0);
    if (!e) h = mq[0];
    chk({tag, ".count"}, 64'(queue_count), 64'(mq.size()));
    chk({tag, ".ready"}, 64'(issue_ready), 64'(mq.size() != QD));
    chk({tag, ".mis"},   64'(misaligned),  64'(exp_mis));
    chk({tag, ".read"},  64'(memory_read),  e ? 64'd0 : 64'(!h.st));
    chk({tag, ".write"}, 64'(memory_write), e ? 64'd0 : 64'(h.st));
    chk({tag, ".addr"},  64'(memory_address), e ? 64'd0 : 64'(h.a));
    chk({tag, ".be"},    64'(memory_byte_en), e ? 64'hF : 64'(h.be));
    chk({tag, ".data"},  64'(memory_data),    e ? 64'd0 : 64'(h.d));
  endtask

  // One clock of stimulus; model advances using pre-edge occupancy
  task automatic step(string tag, bit ld, bit st, logic [AW-1:0] a, logic [DW-1:0] sd,
                      int lb, bit rdy);
    int   pre;
    bit   req;
    bit   full;
    bit   mis;
    bit   push;
    bit   pop;
    ent_t n;
    load = ld; store = st; address = a; store_data = sd;
    log2_bytes = L2'(lb); memory_ready = rdy;
    pre  = mq.size();
    full = (pre == QD);
    req  = ld | st;
`ifdef MEMORY_ISSUE_QUEUE_MISALIGN_CHECK_EN
    mis = (int'(a) % (1 << lb)) != 0;
`else
    mis = 1'b0;
`endif
    push = req && !full && !mis;
    pop  = (pre > 0) && rdy;
    n.st = st; n.a = a; n.be = ref_be(a, lb); n.d = ref_data(sd, lb);
    @(posedge clock);
    #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(n);
    exp_mis = req && !full && mis;
    check_all(tag);
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_mis = 1'b0;
    reset = 1'b0; load = 1'b0; store = 1'b0; address = '0; store_data = '0;
    log2_bytes = '0; memory_ready = 1'b0; scan = 1'b0;

    // 1: reset then idle
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    step("idle", 0, 0, 20'h0, 32'h0, 0, 0);
    chk("idle.be_const", 64'(memory_byte_en), 64'hF);

    // 2: word load at 4, drained immediately
    step("lw", 1, 0, 20'h4, 32'hffffffff, 2, 1);
    chk("lw.data_const", 64'(memory_data), 64'hffffffff);
    step("lw_pop", 0, 0, 20'h0, 32'h0, 0, 1);
    chk("lw_pop.count_const", 64'(queue_count), 64'd0);

    // 3: fill with byte stores while memory stalls
    for (int i = 0; i < 4; i++) step("sb", 0, 1, AW'(i), 32'h000000a5, 0, 0);
    chk("sb.head_be_const", 64'(memory_byte_en), 64'h1);
    chk("sb.head_data_const", 64'(memory_data), 64'ha5a5a5a5);
    step("blocked", 1, 0, 20'h40, 32'h0, 2, 0);
    chk("blocked.ready_const", 64'(issue_ready), 64'd0);

    // 4: pop with blocked push, then push+pop
    step("full_pop", 1, 0, 20'h80, 32'h0, 2, 1);
    chk("full_pop.count_const", 64'(queue_count), 64'd3);
    step("push_pop", 1, 0, 20'h80, 32'h0, 2, 1);
    chk("push_pop.count_const", 64'(queue_count), 64'd3);
    for (int i = 0; i < 4; i++) step("drain", 0, 0, 20'h0, 32'h0, 0, 1);

    // 5: halfword store at 2, then word store at 2
    step("sh", 0, 1, 20'h2, 32'h00001234, 1, 0);
    chk("sh.be_const", 64'(memory_byte_en), 64'hC);
    chk("sh.data_const", 64'(memory_data), 64'h12341234);
    step("sw_mis", 0, 1, 20'h2, 32'hdeadbeef, 2, 0);
    step("after_mis", 0, 0, 20'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) step("drain2", 0, 0, 20'h0, 32'h0, 0, 1);

    // Random traffic, including simultaneous load+store
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'($urandom), 32'($urandom), int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0));
    end

    // 6: asynchronous reset with entries pending
    for (int i = 0; i < 4; i++) step("pre_rst", 1, 0, AW'(16 * i), 32'h0, 2, 0);
    load = 1'b0; store = 1'b0;
    #2 reset = 1'b0;
    #1;
    mq.delete();
    exp_mis = 1'b0;
    check_all("async_rst");
    chk("async_rst.count_const", 64'(queue_count), 64'd0);
    #1 reset = 1'b1;
    step("post_rst", 0, 0, 20'h0, 32'h0, 0, 1);
    step("post_rst_ld", 1, 0, 20'h8, 32'h0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
